// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter among N_REQ requesters.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int STROBE_CYC = 4,
    parameter int GAP_CYC    = 16,
    parameter int TMO_CYC    = 2**20,
    parameter int TMO_W      = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [2:0]         grant_id,
    output logic [7:0]         uart_data,
    output logic               uart_start,
    input  logic               uart_finish,
    output logic               busy,
    output logic               tmo_err
);

    // state    | meaning
    // S_IDLE   | arbitrate among pending requests
    // S_STROBE | gnt cycle, then uart_start high for STROBE_CYC cycles
    // S_LAUNCH | strobe dropped, waiting for finish to go low
    // S_SHIFT  | frame shifting, waiting for finish to return high
    // S_GAP    | enforced idle time before the next frame
    typedef enum logic [2:0] {S_IDLE, S_STROBE, S_LAUNCH, S_SHIFT, S_GAP} state_t;

    localparam int CNT_MAX = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] GAP_LD    = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LD    = TMO_W'(TMO_CYC - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [2:0]         grant_id_nxt;
    logic [7:0]         uart_data_nxt;
    logic               start_nxt;
    logic               tmo_err_nxt;
    logic [2:0]         rr_ptr;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [2:0]         win;
    logic               win_vld;
    logic [7:0]         win_data;
    int                 win_sum;

    // Rotate requests so rr_ptr lands at bit 0; the lowest set bit is then the winner.
    always_comb begin
        req_dbl  = {req, req} >> rr_ptr;
        req_rot  = req_dbl[N_REQ-1:0];
        win_vld  = |req;
        win_sum  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) win_sum = k;
        end
        win_sum = win_sum + int'(rr_ptr);
        if (win_sum >= N_REQ) win_sum = win_sum - N_REQ;
        win      = 3'(win_sum);
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (3'(k) == win) win_data = req_data[8*k +: 8];
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tmo_nxt       = tmo_cnt;
        gnt_nxt       = '0;
        grant_id_nxt  = grant_id;
        uart_data_nxt = uart_data;
        start_nxt     = 1'b0;
        tmo_err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_nxt       = N_REQ'(1) << win;
                    grant_id_nxt  = win;
                    uart_data_nxt = win_data;
                    cnt_nxt       = STROBE_LD;
                    state_nxt     = S_STROBE;
                end
            end
            S_STROBE: begin
                if (cnt != '0) begin
                    start_nxt = 1'b1;
                    cnt_nxt   = cnt - 1'b1;
                end else begin
                    tmo_nxt   = TMO_LD;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (tmo_cnt == '0) begin
                    tmo_err_nxt = 1'b1;
                    cnt_nxt     = GAP_LD;
                    state_nxt   = S_GAP;
                end else begin
                    tmo_nxt = tmo_cnt - 1'b1;
                    if (!uart_finish) state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A finish rising on the terminal-count cycle beats the timeout.
                if (uart_finish) begin
                    cnt_nxt   = GAP_LD;
                    state_nxt = S_GAP;
                end else if (tmo_cnt == '0) begin
                    tmo_err_nxt = 1'b1;
                    cnt_nxt     = GAP_LD;
                    state_nxt   = S_GAP;
                end else begin
                    tmo_nxt = tmo_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tmo_cnt    <= '0;
            gnt        <= '0;
            grant_id   <= '0;
            uart_data  <= '0;
            uart_start <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tmo_cnt    <= tmo_nxt;
            gnt        <= gnt_nxt;
            grant_id   <= grant_id_nxt;
            uart_data  <= uart_data_nxt;
            uart_start <= start_nxt;
            tmo_err    <= tmo_err_nxt;
        end
    end

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       rr_ptr <= '0;
        else if (state == S_IDLE && win_vld) rr_ptr <= (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
    end
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are planned from the arbitration rule
// when requests are issued; a monitor pops and compares on every gnt pulse.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int SC  = 4;
    localparam int GC  = 16;
    localparam int TMO = 8192;  // long enough for a 5100-cycle frame, short enough to simulate a timeout
    localparam int TW  = 14;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [2:0]     grant_id;
    logic [7:0]     uart_data;
    logic           uart_start;
    logic           uart_finish;
    logic           busy;
    logic           tmo_err;

    always #10 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .STROBE_CYC(SC), .GAP_CYC(GC), .TMO_CYC(TMO), .TMO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .grant_id(grant_id), .uart_data(uart_data), .uart_start(uart_start),
        .uart_finish(uart_finish), .busy(busy), .tmo_err(tmo_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Requester side: each requester holds a small ring of bytes and requests while it is non-empty.
    logic [7:0] bytes [N][8];
    int         head [N];
    int         tail [N];
    logic [N-1:0] pulse;
    logic [7:0]   pulse_dat;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i]          = (head[i] != tail[i]) | pulse[i];
            req_data[8*i +: 8] = pulse[i] ? pulse_dat : bytes[i][head[i] % 8];
        end
    end

    task automatic add_byte(input int i, input logic [7:0] d);
        bytes[i][tail[i] % 8] = d;
        tail[i]++;
    endtask

    // Reference model: pending requesters served by scanning from the pointer with wrap.
    int         model_ptr = 0;
    int         exp_id [$];
    logic [7:0] exp_dat [$];

    task automatic issue();
        int h [N];
        int left;
        int w;
        left = 0;
        for (int i = 0; i < N; i++) begin
            h[i] = head[i];
            left += tail[i] - head[i];
        end
        while (left > 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (model_ptr + k) % N;
                if (w < 0 && h[i] != tail[i]) w = i;
            end
            exp_id.push_back(w);
            exp_dat.push_back(bytes[w][h[w] % 8]);
            h[w]++;
            left--;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            model_ptr = (w + 1) % N;
`endif
        end
    endtask

    // Monitor
    int         gnt_cyc = 0, start_rise_cyc = 0, start_fall_cyc = 0, fin_rise_cyc = 0;
    bit         fin_rise_valid = 0;
    logic [7:0] cur_data = '0;
    logic       gnt_prev = 0, start_prev = 0, tmo_prev = 0;
    int         tmo_seen = 0;
    int         pid;
    logic [7:0] pdat;

    always @(negedge clk) begin
        if (!rst_n) begin
            gnt_prev = 0; start_prev = 0; tmo_prev = 0; fin_rise_valid = 0;
        end else begin
            if (gnt != '0) begin
                chk("gnt_pulse_len", 32'(gnt_prev), 0);
                if (exp_id.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 0);
                end else begin
                    pid  = exp_id.pop_front();
                    pdat = exp_dat.pop_front();
                    chk("gnt_onehot", 32'(gnt), 32'(1) << pid);
                    chk("grant_id", 32'(grant_id), 32'(pid));
                    chk("uart_data", 32'(uart_data), 32'(pdat));
                end
                for (int i = 0; i < N; i++)
                    if (gnt[i] && head[i] != tail[i]) head[i]++;
                gnt_cyc  = cyc;
                cur_data = uart_data;
            end
            if (uart_start && !start_prev) begin
                start_rise_cyc = cyc;
                chk("gnt_to_start", 32'(cyc - gnt_cyc), 1);
                if (fin_rise_valid) chk("gap_min", 32'((cyc - fin_rise_cyc) >= GC + 1), 1);
            end
            if (!uart_start && start_prev) begin
                start_fall_cyc = cyc;
                fin_rise_valid = 0;
                chk("strobe_len", 32'(cyc - start_rise_cyc), SC);
                chk("data_at_fall", 32'(uart_data), 32'(cur_data));
            end
            if (tmo_err) begin
                tmo_seen++;
                chk("tmo_latency", 32'(cyc - start_fall_cyc), TMO);
                chk("tmo_pulse_len", 32'(tmo_prev), 0);
            end
            gnt_prev   = (gnt != '0);
            start_prev = uart_start;
            tmo_prev   = tmo_err;
        end
    end

    // Transmitter model: finish drops xm_drop cycles after the strobe falls, stays low xm_low cycles.
    bit   xm_stuck = 0;
    int   xm_drop = 3;
    int   xm_low = 40;
    logic xm_prev = 0;
    logic fell;

    initial begin
        uart_finish = 1'b1;
        forever begin
            @(negedge clk);
            fell    = xm_prev && !uart_start && rst_n;
            xm_prev = uart_start & rst_n;
            if (fell && !xm_stuck) begin
                if (xm_drop == 0) uart_finish = 1'b0;
                else begin
                    repeat (xm_drop) @(posedge clk);
                    #1 uart_finish = 1'b0;
                end
                repeat (xm_low) @(posedge clk);
                #1 uart_finish = 1'b1;
                fin_rise_cyc   = cyc;
                fin_rise_valid = 1;
                chk("data_at_finish", 32'(uart_data), 32'(cur_data));
            end
        end
    end

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1;
        return 0;
    endfunction

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_id.size() != 0 || busy || pending()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_budget", 32'(n < budget), 1);
    endtask

    task automatic wait_gnt(input int idx, input int budget, output int at);
        int n;
        n = 0;
        at = -1;
        while (n < budget && at < 0) begin
            @(negedge clk);
            if (gnt[idx]) at = cyc;
            n++;
        end
        chk("gnt_in_budget", 32'(at >= 0), 1);
    endtask

    int t, n, tmo_exp;

    initial begin
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        pulse = '0;
        pulse_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_uart_data", 32'(uart_data), 0);
        chk("rst_uart_start", 32'(uart_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo_err", 32'(tmo_err), 0);
        @(negedge clk) rst_n = 1'b1;

        // Round-robin with all four requesting
        @(posedge clk); #1;
        add_byte(0, 8'h10); add_byte(0, 8'h10);
        add_byte(1, 8'h11); add_byte(2, 8'h12); add_byte(3, 8'h13);
        issue();
        wait_done(3000);

        // Single long frame from requester 2
        xm_drop = 100; xm_low = 5000;
        @(posedge clk); #1;
        add_byte(2, 8'hA5);
        issue();
        n = cyc;
        wait_gnt(2, 10, t);
        chk("req_to_gnt", 32'(t - n), 1);
        n = 0;
        while (busy && n < 6000) begin @(negedge clk); n++; end
        chk("busy_fall_after_finish", 32'(cyc - fin_rise_cyc), GC + 1);
        chk("no_tmo_yet", 32'(tmo_seen), 0);

        // Timeout on a stuck transmitter, then the next pending request is served
        xm_stuck = 1; xm_drop = 2; xm_low = 30;
        tmo_exp = tmo_seen + 1;
        @(posedge clk); #1;
        add_byte(1, 8'h5C); add_byte(3, 8'hC3);
        issue();
        n = 0;
        while (tmo_seen < tmo_exp && n < TMO + 500) begin @(negedge clk); n++; end
        chk("tmo_seen", 32'(tmo_seen), 32'(tmo_exp));
        xm_stuck = 0;
        wait_done(1000);

        // Late arrival during SHIFT and a withdrawn one-cycle request
        xm_drop = 2; xm_low = 40;
        @(posedge clk); #1;
        add_byte(0, 8'h77);
        issue();
        n = 0;
        while (uart_finish && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #1;
        add_byte(1, 8'h88);
        issue();
        pulse[3] = 1'b1; pulse_dat = 8'hEE;
        @(posedge clk); #1 pulse = '0;
        wait_gnt(1, 300, t);
        chk("late_gnt_after_gap", 32'(t - fin_rise_cyc), GC + 2);
        wait_done(500);

        // Asynchronous reset while the strobe is high
        xm_stuck = 1;
        @(posedge clk); #1;
        add_byte(2, 8'h3C);
        issue();
        n = 0;
        while (!uart_start && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_uart_start", 32'(uart_start), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_uart_data", 32'(uart_data), 0);
        chk("arst_grant_id", 32'(grant_id), 0);
        model_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xm_stuck = 0;
        @(posedge clk); #1;
        add_byte(3, 8'h03); add_byte(0, 8'h01);
        issue();
        wait_done(1000);

        // Requesters 1 and 3 contending; fixed priority starves 3 until 1 is drained
        @(posedge clk); #1;
        add_byte(1, 8'hB1); add_byte(1, 8'hB2); add_byte(1, 8'hB3); add_byte(3, 8'hD3);
        issue();
        wait_done(2000);

        // Randomized batches
        for (int it = 0; it < 20; it++) begin
            xm_drop = $urandom_range(0, 4);
            xm_low  = $urandom_range(8, 80);
            @(posedge clk); #1;
            n = $urandom_range(1, 15);
            for (int i = 0; i < N; i++) begin
                if (n[i]) begin
                    t = $urandom_range(1, 3);
                    for (int b = 0; b < t; b++) add_byte(i, 8'($urandom));
                end
            end
            issue();
            wait_done(4000);
        end

        chk("tmo_total", 32'(tmo_seen), 1);
        chk("exp_queue_empty", 32'(exp_id.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
